// File: rtl/vtc_sprite_renderer_pkg.sv
// Shared constants for the sprite renderer: active-area defaults matching the timing
// controller, sprite geometry, direction state encoding and the colour palette.
package vtc_sprite_renderer_pkg;

  localparam int unsigned VTC_H_ACTIVE = 640;
  localparam int unsigned VTC_V_ACTIVE = 480;
  localparam int unsigned BOX_SIZE     = 32;
  localparam int unsigned STEP         = 2;
  localparam int unsigned GRID_SHIFT   = 6;
  localparam int unsigned POS_W        = 11;
  localparam int unsigned CNT_W        = 3;
  localparam int unsigned CNT_IN_W     = 32;
  localparam int unsigned DIR_W        = 2;
  localparam int unsigned COL_W        = 4;

  localparam logic [DIR_W-1:0] DIR_DR = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DL = 2'b01;
  localparam logic [DIR_W-1:0] DIR_UR = 2'b10;
  localparam logic [DIR_W-1:0] DIR_UL = 2'b11;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = rgb_t'(12'h000);
  localparam rgb_t RGB_GRID  = rgb_t'(12'h444);

  function automatic rgb_t palette(input logic [CNT_W-1:0] idx);
    case (idx)
      3'd0:    return rgb_t'(12'hF00);
      3'd1:    return rgb_t'(12'h0F0);
      3'd2:    return rgb_t'(12'h00F);
      3'd3:    return rgb_t'(12'hFF0);
      3'd4:    return rgb_t'(12'h0FF);
      3'd5:    return rgb_t'(12'hF0F);
      3'd6:    return rgb_t'(12'hFFF);
      default: return rgb_t'(12'hF80);
    endcase
  endfunction

  function automatic logic [DIR_W-1:0] dir_encode(input logic left, input logic up);
    case ({up, left})
      2'b00:   return DIR_DR;
      2'b01:   return DIR_DL;
      2'b10:   return DIR_UR;
      default: return DIR_UL;
    endcase
  endfunction

  function automatic logic dir_is_left(input logic [DIR_W-1:0] dir);
    return (dir == DIR_DL) || (dir == DIR_UL);
  endfunction

  function automatic logic dir_is_up(input logic [DIR_W-1:0] dir);
    return (dir == DIR_UR) || (dir == DIR_UL);
  endfunction

  // One axis move: returns {flip, new_pos}. Reaching the far limit counts as a hit,
  // so the sprite reverses on the same tick it touches the right/bottom edge.
  function automatic logic [POS_W:0] axis_step(input logic [POS_W-1:0] pos,
                                               input logic             neg,
                                               input logic [POS_W-1:0] limit);
    logic [POS_W-1:0] cand;
    cand = pos + POS_W'(STEP);
    if (neg) begin
      if (pos < POS_W'(STEP)) return {1'b1, POS_W'(0)};
      return {1'b0, pos - POS_W'(STEP)};
    end
    if (cand >= limit) return {1'b1, limit};
    return {1'b0, cand};
  endfunction

endpackage

// File: rtl/vtc_sprite_renderer_motion.sv
// Sprite motion: vSync falling-edge frame tick, direction FSM, x/y position and
// bounce counter. State only changes on an unpaused tick.
module vtc_sprite_motion
  import vtc_sprite_renderer_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VTC_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VTC_V_ACTIVE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_pause,
  output logic [POS_W-1:0] o_x,
  output logic [POS_W-1:0] o_y,
  output logic [CNT_W-1:0] o_bounce_cnt
);

  localparam logic [POS_W-1:0] X_LIMIT = POS_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [POS_W-1:0] Y_LIMIT = POS_W'(V_ACTIVE - BOX_SIZE);

  logic             r_vsync_q;
  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic [DIR_W-1:0] r_state;
  logic [CNT_W-1:0] r_bounce_cnt;

  logic             w_tick;
  logic             w_move;
  logic             w_left;
  logic             w_up;
  logic [POS_W:0]   w_step_x;
  logic [POS_W:0]   w_step_y;
  logic [POS_W-1:0] w_next_x;
  logic [POS_W-1:0] w_next_y;
  logic [DIR_W-1:0] w_next_state;
  logic [CNT_W-1:0] w_next_cnt;

  // Next-state logic: both axes evaluated together so a corner flips both at once.
  always_comb begin
    w_tick       = r_vsync_q & ~i_vsync;
    w_move       = w_tick & ~i_pause;
    w_left       = dir_is_left(r_state);
    w_up         = dir_is_up(r_state);
    w_step_x     = axis_step(r_x, w_left, X_LIMIT);
    w_step_y     = axis_step(r_y, w_up, Y_LIMIT);
    w_next_x     = r_x;
    w_next_y     = r_y;
    w_next_state = r_state;
    w_next_cnt   = r_bounce_cnt;
    if (w_move) begin
      w_next_x     = w_step_x[POS_W-1:0];
      w_next_y     = w_step_y[POS_W-1:0];
      w_next_state = dir_encode(w_left ^ w_step_x[POS_W], w_up ^ w_step_y[POS_W]);
      if (w_step_x[POS_W] | w_step_y[POS_W]) begin
        w_next_cnt = r_bounce_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_q    <= 1'b1;
      r_x          <= '0;
      r_y          <= '0;
      r_state      <= DIR_DR;
      r_bounce_cnt <= '0;
    end else begin
      r_vsync_q    <= i_vsync;
      r_x          <= w_next_x;
      r_y          <= w_next_y;
      r_state      <= w_next_state;
      r_bounce_cnt <= w_next_cnt;
    end
  end

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_bounce_cnt = r_bounce_cnt;

endmodule

// File: rtl/vtc_sprite_renderer.sv
// Pixel-colour stage after the video timing controller: grid background plus a
// bouncing sprite, with sync/active strobes re-timed to line up with the RGB outputs.
module vtc_sprite_renderer
  import vtc_sprite_renderer_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VTC_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VTC_V_ACTIVE
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CNT_IN_W-1:0] hPixel_in,
  input  logic [CNT_IN_W-1:0] line_in,
  input  logic                hSync_in,
  input  logic                vSync_in,
  input  logic                video_active_in,
  input  logic                pause,
  output logic [COL_W-1:0]    red,
  output logic [COL_W-1:0]    green,
  output logic [COL_W-1:0]    blue,
  output logic                hSync_out,
  output logic                vSync_out,
  output logic                video_active_out
);

  logic [POS_W-1:0]    w_x;
  logic [POS_W-1:0]    w_y;
  logic [CNT_W-1:0]    w_bounce_cnt;
  logic [CNT_IN_W-1:0] w_x_ext;
  logic [CNT_IN_W-1:0] w_y_ext;
  logic                w_in_box;
  logic                w_on_grid;
  rgb_t                w_rgb;

  logic                r_in_box;
  logic                r_on_grid;
  rgb_t                r_rgb;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_active;

  vtc_sprite_motion #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_motion (
    .i_clk        (clock_in),
    .i_rst_n      (reset),
    .i_vsync      (vSync_in),
    .i_pause      (pause),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_bounce_cnt (w_bounce_cnt)
  );

  // Stage 1 hit tests on the raw 32-bit counters against the zero-extended sprite origin.
  assign w_x_ext   = CNT_IN_W'(w_x);
  assign w_y_ext   = CNT_IN_W'(w_y);
  assign w_in_box  = (hPixel_in >= w_x_ext) && (hPixel_in < w_x_ext + CNT_IN_W'(BOX_SIZE)) &&
                     (line_in >= w_y_ext) && (line_in < w_y_ext + CNT_IN_W'(BOX_SIZE));
  assign w_on_grid = (hPixel_in[GRID_SHIFT-1:0] == '0) || (line_in[GRID_SHIFT-1:0] == '0);

  // Stage 2 colour select; video_active_in is already aligned with the stage-1 result.
  always_comb begin
    w_rgb = RGB_BLACK;
    if (video_active_in) begin
      if (r_in_box) begin
        w_rgb = palette(w_bounce_cnt);
      end else if (r_on_grid) begin
        w_rgb = RGB_GRID;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      r_in_box  <= 1'b0;
      r_on_grid <= 1'b0;
      r_rgb     <= RGB_BLACK;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_active  <= 1'b0;
    end else begin
      r_in_box  <= w_in_box;
      r_on_grid <= w_on_grid;
      r_rgb     <= w_rgb;
      r_hsync   <= hSync_in;
      r_vsync   <= vSync_in;
      r_active  <= video_active_in;
    end
  end

  assign red              = r_rgb.r;
  assign green            = r_rgb.g;
  assign blue             = r_rgb.b;
  assign hSync_out        = r_hsync;
  assign vSync_out        = r_vsync;
  assign video_active_out = r_active;

endmodule

// File: tb/tb_vtc_sprite_renderer.sv
// Self-checking bench for vtc_sprite_renderer: vector table, randomized pixels and
// frame ticks against a behavioural sprite model, plus reset/pause/corner sequences.
module tb_vtc_sprite_renderer;
  import vtc_sprite_renderer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hPixel_in, line_in;
  logic        hSync_in, vSync_in, video_active_in, pause;
  logic [3:0]  red, green, blue, red_sq, green_sq, blue_sq;
  logic        hSync_out, vSync_out, video_active_out;
  logic        hs_sq, vs_sq, act_sq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_sync = 1'b0;

  // Behavioural sprite model, index 0 = 640x480 instance, 1 = 96x96 instance
  int mx[2], my[2], mb[2];
  bit mr[2], md[2];
  int lim_x[2] = '{608, 64};
  int lim_y[2] = '{448, 64};
  logic [11:0] pal[8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                          12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic        act;
    logic [11:0] exp_rgb;
  } vec_t;
  vec_t vecs[10];

  vtc_sprite_renderer dut (
    .clock_in(clk), .reset(reset), .hPixel_in(hPixel_in), .line_in(line_in),
    .hSync_in(hSync_in), .vSync_in(vSync_in), .video_active_in(video_active_in),
    .pause(pause), .red(red), .green(green), .blue(blue),
    .hSync_out(hSync_out), .vSync_out(vSync_out), .video_active_out(video_active_out)
  );

  vtc_sprite_renderer #(.H_ACTIVE(96), .V_ACTIVE(96)) dut_sq (
    .clock_in(clk), .reset(reset), .hPixel_in(hPixel_in), .line_in(line_in),
    .hSync_in(hSync_in), .vSync_in(vSync_in), .video_active_in(video_active_in),
    .pause(pause), .red(red_sq), .green(green_sq), .blue(blue_sq),
    .hSync_out(hs_sq), .vSync_out(vs_sq), .video_active_out(act_sq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    logic hs, vs, av;
    hs = hSync_in; vs = vSync_in; av = video_active_in;
    @(posedge clk); #1;
    if (chk_sync) begin
      chk("hsync_out", hSync_out, hs);
      chk("vsync_out", vSync_out, vs);
      chk("active_out", video_active_out, av);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int l, input bit act, input int k);
    if (!act) return 12'h000;
    if (h >= mx[k] && h < mx[k] + 32 && l >= my[k] && l < my[k] + 32) return pal[mb[k]];
    if (h % 64 == 0 || l % 64 == 0) return 12'h444;
    return 12'h000;
  endfunction

  function automatic logic [1:0] exp_dir(input int k);
    if (mr[k] && md[k]) return DIR_DR;
    if (!mr[k] && md[k]) return DIR_DL;
    if (mr[k]) return DIR_UR;
    return DIR_UL;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 0; my[k] = 0; mb[k] = 0; mr[k] = 1'b1; md[k] = 1'b1;
    end
  endtask

  task automatic model_move();
    for (int k = 0; k < 2; k++) begin
      bit fx, fy;
      fx = 1'b0; fy = 1'b0;
      if (mr[k]) begin
        if (mx[k] + STEP >= lim_x[k]) begin mx[k] = lim_x[k]; fx = 1'b1; end
        else mx[k] = mx[k] + STEP;
      end else if (mx[k] < STEP) begin mx[k] = 0; fx = 1'b1; end
      else mx[k] = mx[k] - STEP;
      if (md[k]) begin
        if (my[k] + STEP >= lim_y[k]) begin my[k] = lim_y[k]; fy = 1'b1; end
        else my[k] = my[k] + STEP;
      end else if (my[k] < STEP) begin my[k] = 0; fy = 1'b1; end
      else my[k] = my[k] - STEP;
      if (fx) mr[k] = ~mr[k];
      if (fy) md[k] = ~md[k];
      if (fx || fy) mb[k] = (mb[k] + 1) % 8;
    end
  endtask

  task automatic check_motion(input string tag);
    chk({tag, "_x"}, dut.u_motion.r_x, mx[0]);
    chk({tag, "_y"}, dut.u_motion.r_y, my[0]);
    chk({tag, "_dir"}, dut.u_motion.r_state, exp_dir(0));
    chk({tag, "_cnt"}, dut.u_motion.r_bounce_cnt, mb[0]);
    chk({tag, "_sq_x"}, dut_sq.u_motion.r_x, mx[1]);
    chk({tag, "_sq_y"}, dut_sq.u_motion.r_y, my[1]);
    chk({tag, "_sq_dir"}, dut_sq.u_motion.r_state, exp_dir(1));
    chk({tag, "_sq_cnt"}, dut_sq.u_motion.r_bounce_cnt, mb[1]);
  endtask

  // One frame: vSync falling edge on the first cycle, released on the second
  task automatic do_tick(input bit p);
    pause = p; vSync_in = 1'b0; hSync_in = 1'($urandom);
    cyc();
    if (!p) model_move();
    vSync_in = 1'b1; hSync_in = 1'($urandom);
    cyc();
    pause = 1'b0;
  endtask

  // Random pixels, biased toward the sprite, with vSync held high so no tick occurs
  task automatic pixel_burst(input int n);
    int ph, pl, h, l;
    bit have_prev;
    have_prev = 1'b0; ph = 0; pl = 0;
    vSync_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(0, 799); l = $urandom_range(0, 524);
      end else begin
        h = mx[0] + $urandom_range(0, 40); h = (h >= 4) ? h - 4 : 0;
        l = my[0] + $urandom_range(0, 40); l = (l >= 4) ? l - 4 : 0;
      end
      hPixel_in = 32'(h); line_in = 32'(l);
      video_active_in = ($urandom_range(0, 4) != 0);
      hSync_in = 1'($urandom);
      cyc();
      if (have_prev) begin
        chk("rand_rgb", {red, green, blue}, exp_rgb(ph, pl, video_active_in, 0));
        chk("rand_rgb_sq", {red_sq, green_sq, blue_sq}, exp_rgb(ph, pl, video_active_in, 1));
      end
      ph = h; pl = l; have_prev = 1'b1;
    end
  endtask

  initial begin
    int sx, sy, sc;
    logic [1:0] sd;
    vecs[0] = '{32'd64,  32'd10,  1'b1, 12'h444};
    vecs[1] = '{32'd5,   32'd5,   1'b1, 12'hF00};
    vecs[2] = '{32'd5,   32'd5,   1'b0, 12'h000};
    vecs[3] = '{32'd100, 32'd100, 1'b1, 12'h000};
    vecs[4] = '{32'd31,  32'd31,  1'b1, 12'hF00};
    vecs[5] = '{32'd32,  32'd31,  1'b1, 12'h000};
    vecs[6] = '{32'd200, 32'd128, 1'b1, 12'h444};
    vecs[7] = '{32'd0,   32'd0,   1'b0, 12'h000};
    vecs[8] = '{32'd639, 32'd479, 1'b1, 12'h000};
    vecs[9] = '{32'd640, 32'd0,   1'b1, 12'h444};

    reset = 1'b1; pause = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
    video_active_in = 1'b0; hPixel_in = '0; line_in = '0;
    model_reset();
    #1 reset = 1'b0;

    // Reset held with toggling inputs
    for (int i = 0; i < 5; i++) begin
      hPixel_in = 32'($urandom_range(0, 40)); line_in = 32'($urandom_range(0, 40));
      hSync_in = 1'($urandom); vSync_in = 1'($urandom);
      video_active_in = 1'b1; pause = 1'($urandom);
      cyc();
      chk("rst_rgb", {red, green, blue}, 12'h000);
      chk("rst_hsync", hSync_out, 1);
      chk("rst_vsync", vSync_out, 1);
      chk("rst_active", video_active_out, 0);
    end
    vSync_in = 1'b1; pause = 1'b0; video_active_in = 1'b0;
    reset = 1'b1;
    cyc();
    chk_sync = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      hPixel_in = vecs[i].h; line_in = vecs[i].l;
      video_active_in = vecs[i].act; hSync_in = 1'($urandom);
      cyc();
      cyc();
      chk("vec_rgb", {red, green, blue}, vecs[i].exp_rgb);
    end

    pixel_burst(200);

    // Ten frames from reset: sprite at (20,20) still heading down-right
    for (int i = 0; i < 10; i++) do_tick(1'b0);
    chk("f10_x", dut.u_motion.r_x, 20);
    chk("f10_y", dut.u_motion.r_y, 20);
    chk("f10_dir", dut.u_motion.r_state, DIR_DR);
    check_motion("f10");

    // Pause across three ticks freezes everything
    sx = dut.u_motion.r_x; sy = dut.u_motion.r_y;
    sd = dut.u_motion.r_state; sc = dut.u_motion.r_bounce_cnt;
    for (int i = 0; i < 3; i++) do_tick(1'b1);
    chk("pause_x", dut.u_motion.r_x, sx);
    chk("pause_y", dut.u_motion.r_y, sy);
    chk("pause_dir", dut.u_motion.r_state, sd);
    chk("pause_cnt", dut.u_motion.r_bounce_cnt, sc);
    check_motion("pause");

    // 22 more moves: square instance lands in its corner, flipping both axes once
    for (int i = 0; i < 22; i++) do_tick(1'b0);
    chk("corner_sq_x", dut_sq.u_motion.r_x, 64);
    chk("corner_sq_y", dut_sq.u_motion.r_y, 64);
    chk("corner_sq_dir", dut_sq.u_motion.r_state, DIR_UL);
    chk("corner_sq_cnt", dut_sq.u_motion.r_bounce_cnt, 1);
    chk("f32_x", dut.u_motion.r_x, 64);
    check_motion("f32");
    pixel_burst(40);

    // Long random run covering the edge bounces of both instances
    for (int t = 0; t < 1400; t++) begin
      do_tick($urandom_range(0, 9) < 3);
      check_motion("run");
      if (t % 100 == 99) pixel_burst(30);
    end

    // Asynchronous reset mid-frame
    hPixel_in = 32'(mx[0]); line_in = 32'(my[0]);
    video_active_in = 1'b1; hSync_in = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_rgb", {red, green, blue}, pal[mb[0]]);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rgb", {red, green, blue}, 12'h000);
    chk("mid_rst_hsync", hSync_out, 1);
    chk("mid_rst_active", video_active_out, 0);
    chk("mid_rst_x", dut.u_motion.r_x, 0);
    chk("mid_rst_dir", dut.u_motion.r_state, DIR_DR);
    chk_sync = 1'b0;
    hSync_in = 1'b1; vSync_in = 1'b1; video_active_in = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    model_reset();
    cyc();
    chk_sync = 1'b1;
    do_tick(1'b0);
    chk("after_rst_x", dut.u_motion.r_x, 2);
    chk("after_rst_y", dut.u_motion.r_y, 2);
    chk("after_rst_dir", dut.u_motion.r_state, DIR_DR);
    check_motion("after_rst");
    pixel_burst(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
